// File: rtl/main_controller_pkg.sv
// Shared constants for the multicycle MIPS main controller:
// state codes, opcode/funct values, ALU encodings and the control bundle.
package main_controller_pkg;

  localparam logic [3:0] S_RST     = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_MEMADR  = 4'd3;
  localparam logic [3:0] S_MEMRD   = 4'd4;
  localparam logic [3:0] S_MEMWB   = 4'd5;
  localparam logic [3:0] S_MEMWR   = 4'd6;
  localparam logic [3:0] S_RTYPEEX = 4'd7;
  localparam logic [3:0] S_RTYPEWB = 4'd8;
  localparam logic [3:0] S_BEQ     = 4'd9;
  localparam logic [3:0] S_ADDIEX  = 4'd10;
  localparam logic [3:0] S_ADDIWB  = 4'd11;
  localparam logic [3:0] S_JUMP    = 4'd12;
  localparam logic [3:0] S_JAL     = 4'd13;
  localparam logic [3:0] S_ILLEGAL = 4'd14;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef struct packed {
    logic [1:0] alu_control;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       is_interrupted;
    logic       is_branch;
    logic       pc_write;
    logic       lor_d;
    logic       mem_write;
    logic       ir_write;
    logic       irq_ack;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/main_controller_alu_decoder.sv
// Maps an R-type funct field to the 2-bit ALU operation.
// Ports: funct in, aluControl out, legal = funct is one we implement.
module alu_decoder
  import main_controller_pkg::*;
(
  input  logic [5:0] funct,
  output logic [1:0] aluControl,
  output logic       legal
);

  always_comb begin
    aluControl = ALU_ADD;
    legal      = 1'b1;
    case (funct)
      FN_ADD:  aluControl = ALU_ADD;
      FN_SUB:  aluControl = ALU_SUB;
      FN_AND:  aluControl = ALU_AND;
      FN_OR:   aluControl = ALU_OR;
      default: legal      = 1'b0;
    endcase
  end

endmodule

// File: rtl/main_controller.sv
// Moore FSM driving the multicycle DataPath, with level-irq latch.
// Ports: clk/resetN, op/funct from IR, irq in; DataPath controls out.
module main_controller
  import main_controller_pkg::*;
(
  input  logic       clk,
  input  logic       resetN,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       irq,
  output logic [1:0] aluControl,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] pcSource,
  output logic [1:0] regWrite,
  output logic [1:0] regDst,
  output logic [1:0] memToReg,
  output logic       isInterrupted,
  output logic       isBranch,
  output logic       pcWrite,
  output logic       lorD,
  output logic       memWrite,
  output logic       IrWrite,
  output logic       irqAck,
  output logic       illegalOp
);

  logic [3:0] state_q, state_d;
  logic       pend_q, pend_d;
  logic [1:0] fn_alu;
  logic       fn_legal;
  ctrl_t      ctrl;

  alu_decoder u_alu_dec (
    .funct      (funct),
    .aluControl (fn_alu),
    .legal      (fn_legal)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_RST;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // A new irq in the servicing FETCH keeps the flag set.
  always_comb begin
    pend_d = pend_q;
    if (irq)
      pend_d = 1'b1;
    else if (state_q == S_FETCH)
      pend_d = 1'b0;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:
            state_d = fn_legal ? S_RTYPEEX : S_ILLEGAL;
          OP_BEQ:  state_d = S_BEQ;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          OP_JAL:  state_d = S_JAL;
          default: state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.ir_write       = 1'b1;
        ctrl.alu_src_b      = 2'b01;
        ctrl.pc_write       = 1'b1;
        ctrl.is_interrupted = pend_q;
        ctrl.irq_ack        = pend_q;
      end
      S_DECODE: ctrl.alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b10;
      end
      S_MEMRD: ctrl.lor_d = 1'b1;
      S_MEMWB: begin
        ctrl.mem_to_reg = 2'b01;
        ctrl.reg_write  = 2'b01;
      end
      S_MEMWR: begin
        ctrl.lor_d     = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alu_src_a   = 2'b01;
        ctrl.alu_control = fn_alu;
      end
      S_RTYPEWB: begin
        ctrl.reg_dst   = 2'b01;
        ctrl.reg_write = 2'b01;
      end
      S_ADDIWB: ctrl.reg_write = 2'b01;
      S_BEQ: begin
        ctrl.alu_src_a   = 2'b01;
        ctrl.alu_control = ALU_SUB;
        ctrl.pc_source   = 2'b01;
        ctrl.is_branch   = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_source = 2'b10;
        ctrl.pc_write  = 1'b1;
      end
      S_JAL: begin
        ctrl.pc_source  = 2'b10;
        ctrl.pc_write   = 1'b1;
        ctrl.reg_dst    = 2'b10;
        ctrl.mem_to_reg = 2'b10;
        ctrl.reg_write  = 2'b01;
      end
      S_ILLEGAL: ctrl.illegal_op = 1'b1;
      default: ctrl = '0;
    endcase
  end

  assign aluControl    = ctrl.alu_control;
  assign aluSrcA       = ctrl.alu_src_a;
  assign aluSrcB       = ctrl.alu_src_b;
  assign pcSource      = ctrl.pc_source;
  assign regWrite      = ctrl.reg_write;
  assign regDst        = ctrl.reg_dst;
  assign memToReg      = ctrl.mem_to_reg;
  assign isInterrupted = ctrl.is_interrupted;
  assign isBranch      = ctrl.is_branch;
  assign pcWrite       = ctrl.pc_write;
  assign lorD          = ctrl.lor_d;
  assign memWrite      = ctrl.mem_write;
  assign IrWrite       = ctrl.ir_write;
  assign irqAck        = ctrl.irq_ack;
  assign illegalOp     = ctrl.illegal_op;

endmodule

// File: tb/tb_main_controller.sv
// Self-checking bench for main_controller: directed table,
// random instruction stream vs per-instruction model, reset corners.
module tb_main_controller;

  typedef struct packed {
    logic [1:0] alu;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] pcs;
    logic [1:0] rw;
    logic [1:0] rdst;
    logic [1:0] m2r;
    logic       isint;
    logic       isbr;
    logic       pcw;
    logic       lord;
    logic       memw;
    logic       irw;
    logic       ack;
    logic       ill;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [7:0] irqm;
    int         len;
  } vec_t;

  localparam int C_LW = 0, C_SW = 1, C_RT = 2, C_BEQ = 3;
  localparam int C_ADDI = 4, C_J = 5, C_JAL = 6, C_ILL = 7;

  logic       clk = 1'b0;
  logic       resetN;
  logic [5:0] op, funct;
  logic       irq;
  logic [1:0] aluControl, aluSrcA, aluSrcB, pcSource;
  logic [1:0] regWrite, regDst, memToReg;
  logic       isInterrupted, isBranch, pcWrite, lorD;
  logic       memWrite, IrWrite, irqAck, illegalOp;
  outs_t      got;

  int checks = 0;
  int errors = 0;
  bit pend;
  vec_t tbl[16];

  always #5 clk = ~clk;

  main_controller dut (
    .clk           (clk),
    .resetN        (resetN),
    .op            (op),
    .funct         (funct),
    .irq           (irq),
    .aluControl    (aluControl),
    .aluSrcA       (aluSrcA),
    .aluSrcB       (aluSrcB),
    .pcSource      (pcSource),
    .regWrite      (regWrite),
    .regDst        (regDst),
    .memToReg      (memToReg),
    .isInterrupted (isInterrupted),
    .isBranch      (isBranch),
    .pcWrite       (pcWrite),
    .lorD          (lorD),
    .memWrite      (memWrite),
    .IrWrite       (IrWrite),
    .irqAck        (irqAck),
    .illegalOp     (illegalOp)
  );

  assign got = {aluControl, aluSrcA, aluSrcB, pcSource,
                regWrite, regDst, memToReg, isInterrupted,
                isBranch, pcWrite, lorD, memWrite, IrWrite,
                irqAck, illegalOp};

  task automatic check(input string name,
                       input logic [31:0] g,
                       input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, g, e);
    end
  endtask

  function automatic int cls(input logic [5:0] o,
                             input logic [5:0] f);
    case (o)
      6'h23: return C_LW;
      6'h2B: return C_SW;
      6'h00: begin
        if (f == 6'h20 || f == 6'h22 ||
            f == 6'h24 || f == 6'h25)
          return C_RT;
        return C_ILL;
      end
      6'h04: return C_BEQ;
      6'h08: return C_ADDI;
      6'h02: return C_J;
      6'h03: return C_JAL;
      default: return C_ILL;
    endcase
  endfunction

  function automatic int len_of(input int c);
    if (c == C_LW) return 5;
    if (c == C_SW || c == C_RT || c == C_ADDI) return 4;
    return 3;
  endfunction

  // Expected outputs for cycle 'step' of an instruction (0 = FETCH).
  function automatic outs_t model(input int c, input int step,
                                  input bit p,
                                  input logic [5:0] f);
    outs_t e = '0;
    if (step == 0) begin
      e.irw = 1; e.srcb = 2'b01; e.pcw = 1;
      e.isint = p; e.ack = p;
    end else if (step == 1) begin
      e.srcb = 2'b11;
    end else begin
      case (c)
        C_LW, C_SW, C_ADDI: begin
          if (step == 2) begin
            e.srca = 2'b01; e.srcb = 2'b10;
          end else if (c == C_ADDI) begin
            e.rw = 2'b01;
          end else if (c == C_SW) begin
            e.lord = 1; e.memw = 1;
          end else if (step == 3) begin
            e.lord = 1;
          end else begin
            e.m2r = 2'b01; e.rw = 2'b01;
          end
        end
        C_RT: begin
          if (step == 2) begin
            e.srca = 2'b01;
            e.alu = (f == 6'h22) ? 2'b01 :
                    (f == 6'h24) ? 2'b10 :
                    (f == 6'h25) ? 2'b11 : 2'b00;
          end else begin
            e.rdst = 2'b01; e.rw = 2'b01;
          end
        end
        C_BEQ: begin
          e.srca = 2'b01; e.alu = 2'b01;
          e.pcs = 2'b01; e.isbr = 1;
        end
        C_J: begin
          e.pcs = 2'b10; e.pcw = 1;
        end
        C_JAL: begin
          e.pcs = 2'b10; e.pcw = 1; e.rdst = 2'b10;
          e.m2r = 2'b10; e.rw = 2'b01;
        end
        default: e.ill = 1;
      endcase
    end
    return e;
  endfunction

  // Starts in FETCH; runs until the next FETCH (bounded).
  task automatic run_instr(input logic [5:0] o,
                           input logic [5:0] f,
                           input logic [7:0] irqm,
                           input int exp_len,
                           input string tag);
    int c = cls(o, f);
    int n = 0;
    op = o;
    funct = f;
    do begin
      if (n < len_of(c))
        check($sformatf("%s_s%0d", tag, n), 32'(got),
              32'(model(c, n, pend, f)));
      irq = (n < 8) ? irqm[n] : 1'b0;
      if (irq) pend = 1'b1;
      else if (n == 0) pend = 1'b0;
      @(posedge clk);
      #1;
      irq = 1'b0;
      n++;
    end while (IrWrite !== 1'b1 && n < 10);
    check($sformatf("%s_len", tag), 32'(n), 32'(exp_len));
  endtask

  initial begin
    tbl[0]  = '{6'h23, 6'h00, 8'h00, 5};
    tbl[1]  = '{6'h2B, 6'h00, 8'h00, 4};
    tbl[2]  = '{6'h00, 6'h20, 8'h00, 4};
    tbl[3]  = '{6'h00, 6'h22, 8'h00, 4};
    tbl[4]  = '{6'h00, 6'h24, 8'h00, 4};
    tbl[5]  = '{6'h00, 6'h25, 8'h00, 4};
    tbl[6]  = '{6'h00, 6'h21, 8'h00, 3};
    tbl[7]  = '{6'h04, 6'h00, 8'h00, 3};
    tbl[8]  = '{6'h08, 6'h00, 8'h00, 4};
    tbl[9]  = '{6'h02, 6'h00, 8'h00, 3};
    tbl[10] = '{6'h03, 6'h00, 8'h00, 3};
    tbl[11] = '{6'h3F, 6'h00, 8'h00, 3};
    tbl[12] = '{6'h23, 6'h00, 8'h08, 5};
    tbl[13] = '{6'h2B, 6'h00, 8'h01, 4};
    tbl[14] = '{6'h02, 6'h00, 8'h00, 3};
    tbl[15] = '{6'h02, 6'h00, 8'h00, 3};

    resetN = 1'b0;
    op = 6'h00;
    funct = 6'h00;
    irq = 1'b0;
    pend = 1'b0;
    #2;
    check("reset_async", 32'(got), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 32'(got), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    #1;
    check("rst_state", 32'(got), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      if (i == 13)
        check("irq_ack", {isInterrupted, irqAck}, 2'b11);
      if (i == 15)
        check("irq_clear", 32'(isInterrupted), 32'd0);
      run_instr(tbl[i].op, tbl[i].fn, tbl[i].irqm,
                tbl[i].len, $sformatf("vec%0d", i));
    end

    for (int k = 0; k < 150; k++) begin
      logic [5:0] ro, rf;
      logic [7:0] rm;
      int pick;
      pick = $urandom_range(0, 9);
      case (pick)
        0: ro = 6'h23;
        1: ro = 6'h2B;
        2: ro = 6'h00;
        3: ro = 6'h04;
        4: ro = 6'h08;
        5: ro = 6'h02;
        6: ro = 6'h03;
        7: ro = 6'h00;
        default: ro = 6'($urandom);
      endcase
      if ($urandom_range(0, 1) == 0)
        rf = 6'h20 + 6'($urandom_range(0, 5));
      else
        rf = 6'($urandom);
      rm = ($urandom_range(0, 3) == 0) ?
           (8'($urandom) & 8'h1F) : 8'h00;
      run_instr(ro, rf, rm, len_of(cls(ro, rf)),
                $sformatf("rnd%0d", k));
    end

    // Reset during a store: write enable must drop without a clock.
    op = 6'h2B;
    funct = 6'h00;
    repeat (3) @(posedge clk);
    #1;
    pend = 1'b0;
    check("memwr_pre", 32'(memWrite), 32'd1);
    resetN = 1'b0;
    #1;
    check("memwr_rst", 32'(got), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;
    run_instr(6'h23, 6'h00, 8'h00, 5, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_controller.md
MAIN_CONTROLLER -- requirements
Module: main_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, as listed below.
REQ-002 The ports SHALL be, one per line: name, direction, width, meaning. Clock and reset come first.
clk  in  1  rising-edge clock, shared with DataPath
resetN  in  1  asynchronous active-low reset
op  in  6  instr[31:26], from DataPath
funct  in  6  instr[5:0], from DataPath
irq  in  1  level interrupt request
aluControl  out  2  00 ADD, 01 SUB, 10 AND, 11 OR
aluSrcA  out  2  00 pcOut2, 01 aData2; bit1 always 0
aluSrcB  out  2  00 B reg, 01 four, 10 signImm, 11 shiftedSignImm
pcSource  out  2  00 aluResult, 01 aluOut, 10 jump target, 11 zero
regWrite  out  2  register-file write enable in bit0; bit1 always 0
regDst  out  2  00 rt, 01 rd, 10 $31, 11 rs
memToReg  out  2  00 aluOut, 01 data, 10 pcOut, 11 zero
isInterrupted, isBranch, pcWrite, lorD, memWrite, IrWrite  out  1 each  DataPath controls
irqAck  out  1  one-cycle pulse when the interrupt vector fetch occurs
illegalOp  out  1  one-cycle pulse on an undecodable instruction

Function
REQ-003 The block SHALL be a Moore FSM. All outputs SHALL be decoded from the registered state and the irqPending flag only. The one exception is aluControl in RTYPEEX, which SHALL also decode funct.
REQ-004 The block SHALL have the 15 states RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQ, ADDIEX, ADDIWB, JUMP, JAL and ILLEGAL, held in a 4-bit state register.
REQ-005 Every output SHALL be 0 in any state except where it is set by REQ-006 to REQ-011.
REQ-006 Transitions:
- RST -> FETCH
- FETCH -> DECODE
- DECODE dispatches on op:
  - 0x23 or 0x2B -> MEMADR
  - 0x00 with funct in {0x20, 0x22, 0x24, 0x25} -> RTYPEEX
  - 0x04 -> BEQ
  - 0x08 -> ADDIEX
  - 0x02 -> JUMP
  - 0x03 -> JAL
  - anything else -> ILLEGAL
- MEMADR -> MEMRD if op = 0x23, else MEMWR
- MEMRD -> MEMWB
- RTYPEEX -> RTYPEWB
- ADDIEX -> ADDIWB
- MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQ, JUMP, JAL and ILLEGAL -> FETCH
REQ-007 Outputs in FETCH: lorD=0, IrWrite=1, aluSrcA=00, aluSrcB=01, aluControl=ADD, pcSource=00, pcWrite=1, isInterrupted=irqPending, irqAck=irqPending.
REQ-008 Outputs in DECODE: aluSrcA=00, aluSrcB=11, ADD.
REQ-009 Outputs in the memory states:
- MEMADR and ADDIEX: aluSrcA=01, aluSrcB=10, ADD.
- MEMRD: lorD=1.
- MEMWB: regDst=00, memToReg=01, regWrite=01.
- MEMWR: lorD=1, memWrite=1.
REQ-010 Outputs in the ALU states:
- RTYPEEX: aluSrcA=01, aluSrcB=00, aluControl from the funct map 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR.
- RTYPEWB: regDst=01, memToReg=00, regWrite=01.
- ADDIWB: regDst=00, memToReg=00, regWrite=01.
REQ-011 Outputs in the control-flow states:
- BEQ: aluSrcA=01, aluSrcB=00, SUB, pcSource=01, isBranch=1.
- JUMP: pcSource=10, pcWrite=1.
- JAL: pcSource=10, pcWrite=1, regDst=10, memToReg=10, regWrite=01.
- ILLEGAL: illegalOp=1.
REQ-012 Instruction latency in clocks, counting from FETCH:
- lw 5
- sw, R-type, addi 4
- beq, j, jal, illegal 3
REQ-013 The irqPending flag SHALL follow these rules:
- It SHALL be set on any clock where irq=1.
- It SHALL clear at the end of a FETCH in which it was 1.
- If irq=1 during that same FETCH, set SHALL win.
REQ-014 An irq arriving mid-instruction SHALL NOT alter the current instruction. It SHALL be serviced at the next FETCH.

Reset
REQ-015 When resetN=0, the state SHALL go to RST and irqPending SHALL go to 0 immediately, without waiting for clk.
REQ-016 In RST all outputs SHALL be 0. The first FETCH SHALL occur on the first rising edge after resetN rises.
REQ-017 If reset is asserted mid-instruction, the instruction SHALL be abandoned. No write enable SHALL be asserted until FETCH.

Structure
REQ-018 The shared package SHALL hold the state encodings, the opcode constants (0x00, 0x23, 0x2B, 0x04, 0x08, 0x02, 0x03), the funct constants and the aluControl encodings.
REQ-019 The funct-to-aluControl map SHALL be a sub-module named alu_decoder (funct in, aluControl out, plus a legal flag).
REQ-020 The combined main_controller + DataPath SHALL be the CPU top.

Verification
REQ-021 Reset, then release -> RST for 1 cycle. Then FETCH with pcWrite=1, IrWrite=1, aluSrcB=01.
REQ-022 op=0x23 -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. In MEMWB: memToReg=01, regWrite=01. 5 cycles in total.
REQ-023 op=0x00, funct=0x22 -> RTYPEEX drives aluControl=01. RTYPEWB drives regDst=01.
REQ-024 op=0x04 -> BEQ drives isBranch=1, pcSource=01, SUB. op=0x03 -> JAL drives regDst=10, memToReg=10, pcSource=10.
REQ-025 irq pulsed for 1 cycle during MEMRD -> the lw completes. In the next FETCH: isInterrupted=1 and irqAck=1. In the following FETCH: isInterrupted=0.
REQ-026 op=0x3F -> ILLEGAL with illegalOp=1 and no write enables. Then FETCH. Separately, resetN pulsed low in MEMWR -> memWrite drops to 0 immediately.
